// File: rtl/trig_matrix_v2.sv
// trig_matrix_v2 -- configurable trigger routing matrix.
//
// Each output picks one registered trigger input (sel), optionally inverts
// it, and either follows it (level mode) or fires a fixed-length,
// non-retriggerable pulse on its rising edge (oneshot mode). Every input
// and output also drives an activity LED with a hold time.
//
// Ports:
//   clk            single clock
//   rst            synchronous, active-high reset
//   trig_in        trigger inputs (already in clk domain)
//   trig_out       routed trigger outputs (2 cycles after trig_in)
//   cfg_wr/cfg_rd  register write / read strobes, accepted every cycle
//   cfg_addr       register address (0..NUM_OUT-1 = per-output config)
//   cfg_wdata      write data: [7:0] sel, [8] invert, [9] oneshot, [31:16] width
//   cfg_rdata      read data, valid the cycle after cfg_rd, else 0
//   cfg_rd_valid   one-cycle read-data-valid
//   trig_in_led    input activity LEDs
//   trig_out_led   output activity LEDs
//
// Optional feature: define TRIG_MATRIX_STATS_EN to add a saturating 32-bit
// rising-edge counter per input, read at 0x80+i, cleared by any write there.
module trig_matrix_v2 #(
    parameter int NUM_IN   = 12,
    parameter int NUM_OUT  = 14,
    parameter int LED_HOLD = 25000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IN-1:0]  trig_in,
    output logic [NUM_OUT-1:0] trig_out,
    input  logic               cfg_wr,
    input  logic               cfg_rd,
    input  logic [7:0]         cfg_addr,
    input  logic [31:0]        cfg_wdata,
    output logic [31:0]        cfg_rdata,
    output logic               cfg_rd_valid,
    output logic [NUM_IN-1:0]  trig_in_led,
    output logic [NUM_OUT-1:0] trig_out_led
);

    localparam int                LW         = (LED_HOLD > 1) ? $clog2(LED_HOLD) : 1;
    localparam logic [LW-1:0]     LED_RELOAD = LW'(LED_HOLD - 1);

    logic [NUM_IN-1:0]        r_in_q;
    logic [255:0]             w_in_pad;     // in_q padded so any 8-bit sel indexes safely
    logic [NUM_OUT-1:0][31:0] w_cfg_rd;
    logic [31:0]              w_rd_data;
    logic                     w_unused_wdata;

    assign w_in_pad       = 256'(r_in_q);
    assign w_unused_wdata = ^cfg_wdata[15:10];

    always_ff @(posedge clk) begin
        if (rst) r_in_q <= '0;
        else     r_in_q <= trig_in;
    end

    // ---------------- per-output routing ----------------
    for (genvar g = 0; g < NUM_OUT; g++) begin : g_out
        logic [7:0]  r_sel;
        logic        r_inv;
        logic        r_os;
        logic [15:0] r_width;
        logic [15:0] r_cnt;
        logic        r_prev;
        logic        r_trig_out;
        logic        w_wr;
        logic        w_src;
        logic        w_src_new;
        logic [15:0] w_load;

        assign w_wr   = cfg_wr && (cfg_addr == 8'(g));
        assign w_src  = (r_sel < 8'(NUM_IN)) && (w_in_pad[r_sel] ^ r_inv);
        // Source as it will be under the config being written, so the edge
        // detector is primed and a write alone never looks like an edge.
        assign w_src_new = (cfg_wdata[7:0] < 8'(NUM_IN)) &&
                           (w_in_pad[cfg_wdata[7:0]] ^ cfg_wdata[8]);
        assign w_load = (r_width == 16'd0) ? 16'd1 : r_width;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_sel      <= 8'hFF;
                r_inv      <= 1'b0;
                r_os       <= 1'b0;
                r_width    <= 16'd0;
                r_cnt      <= 16'd0;
                r_prev     <= 1'b0;
                r_trig_out <= 1'b0;
            end else if (w_wr) begin
                r_sel      <= cfg_wdata[7:0];
                r_inv      <= cfg_wdata[8];
                r_os       <= cfg_wdata[9];
                r_width    <= cfg_wdata[31:16];
                r_cnt      <= 16'd0;
                r_prev     <= w_src_new;
                r_trig_out <= 1'b0;
            end else begin
                r_prev <= w_src;
                if (!r_os) begin
                    r_cnt      <= 16'd0;
                    r_trig_out <= w_src;
                end else if (r_cnt != 16'd0) begin
                    // busy: edges ignored, output stays high until count hits 0
                    r_cnt      <= r_cnt - 16'd1;
                    r_trig_out <= (r_cnt != 16'd1);
                end else if (w_src && !r_prev) begin
                    r_cnt      <= w_load;
                    r_trig_out <= 1'b1;
                end else begin
                    r_trig_out <= 1'b0;
                end
            end
        end

        assign trig_out[g] = r_trig_out;
        assign w_cfg_rd[g] = {r_width, 6'd0, r_os, r_inv, r_sel};
    end

    // ---------------- activity LEDs ----------------
    for (genvar g = 0; g < NUM_IN; g++) begin : g_in_led
        logic [LW-1:0] r_hold;
        always_ff @(posedge clk) begin
            if (rst)                 r_hold <= '0;
            else if (r_in_q[g])      r_hold <= LED_RELOAD;
            else if (r_hold != '0)   r_hold <= r_hold - 1'b1;
        end
        assign trig_in_led[g] = r_in_q[g] | (r_hold != '0);
    end

    for (genvar g = 0; g < NUM_OUT; g++) begin : g_out_led
        logic [LW-1:0] r_hold;
        always_ff @(posedge clk) begin
            if (rst)                 r_hold <= '0;
            else if (trig_out[g])    r_hold <= LED_RELOAD;
            else if (r_hold != '0)   r_hold <= r_hold - 1'b1;
        end
        assign trig_out_led[g] = trig_out[g] | (r_hold != '0);
    end

    // ---------------- optional edge statistics ----------------
`ifdef TRIG_MATRIX_STATS_EN
    logic [NUM_IN-1:0]       r_in_qq;
    logic [NUM_IN-1:0][31:0] w_stat;

    always_ff @(posedge clk) begin
        if (rst) r_in_qq <= '0;
        else     r_in_qq <= r_in_q;
    end

    for (genvar g = 0; g < NUM_IN; g++) begin : g_stat
        logic [31:0] r_edges;
        logic        w_clr;
        logic        w_edge;
        assign w_clr  = cfg_wr && (cfg_addr == 8'(128 + g));
        assign w_edge = r_in_q[g] && !r_in_qq[g];
        always_ff @(posedge clk) begin
            if (rst)                               r_edges <= 32'd0;
            else if (w_clr)                        r_edges <= {31'd0, w_edge};
            else if (w_edge && (r_edges != '1))    r_edges <= r_edges + 32'd1;
        end
        assign w_stat[g] = r_edges;
    end
`endif

    // ---------------- register read ----------------
    // Reads sample register state before any same-cycle write lands.
    always_comb begin
        w_rd_data = '0;
        for (int o = 0; o < NUM_OUT; o++)
            if (cfg_addr == 8'(o)) w_rd_data = w_cfg_rd[o];
`ifdef TRIG_MATRIX_STATS_EN
        for (int i = 0; i < NUM_IN; i++)
            if (cfg_addr == 8'(128 + i)) w_rd_data = w_stat[i];
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_rd_valid <= 1'b0;
            cfg_rdata    <= 32'd0;
        end else begin
            cfg_rd_valid <= cfg_rd;
            cfg_rdata    <= cfg_rd ? w_rd_data : 32'd0;
        end
    end

endmodule

// File: doc/trig_matrix_v2.md
TRIG_MATRIX_V2 -- requirements
Module: trig_matrix_v2

Interface
REQ-001 Parameter NUM_IN, default 12: number of trigger inputs (1..128).
REQ-002 Parameter NUM_OUT, default 14: number of trigger outputs (1..128).
REQ-003 Parameter LED_HOLD, default 25000000: activity LED hold time, in clk cycles.
REQ-004 Port clk, input, 1: the single clock for all logic.
REQ-005 Port rst, input, 1: reset, synchronous and active-high.
REQ-006 Port trig_in, input, NUM_IN: trigger inputs, already in the clk domain.
REQ-007 Port trig_out, output, NUM_OUT: routed trigger outputs.
REQ-008 Port cfg_wr, input, 1: register write strobe.
REQ-009 Port cfg_rd, input, 1: register read strobe.
REQ-010 Port cfg_addr, input, 8: register address.
REQ-011 Port cfg_wdata, input, 32: write data.
REQ-012 Port cfg_rdata, output, 32: read data.
REQ-013 Port cfg_rd_valid, output, 1: read data valid.
REQ-014 Port trig_in_led, output, NUM_IN: input activity LEDs.
REQ-015 Port trig_out_led, output, NUM_OUT: output activity LEDs.

Function
REQ-016 Addresses 0..NUM_OUT-1 SHALL each select one per-output config register with these fields:
- [7:0] sel
- [8] invert
- [9] oneshot
- [31:16] width
REQ-017 Every trig_in bit SHALL be registered once (in_q). Each output SHALL then be registered from src = in_q[sel] XOR invert, giving 2-cycle latency from trig_in to trig_out.
REQ-018 If sel >= NUM_IN, the output SHALL be disabled: trig_out is 0 regardless of invert or oneshot.
REQ-019 Level mode (oneshot=0): trig_out SHALL follow src.
REQ-020 Oneshot mode, rising edge of src: load a 16-bit counter with max(width,1) and drive trig_out high while the counter is nonzero. Exact pulse length = max(width,1) cycles.
REQ-021 Oneshot mode SHALL be non-retriggerable: src edges SHALL be ignored while the counter is nonzero.
REQ-022 A rising edge on the cycle the counter reaches 1 SHALL be ignored; the next edge after the output falls SHALL fire.
REQ-023 A config write to an output SHALL clear its counter. The new config SHALL take effect on the cycle after the write; trig_out SHALL reflect it 1 cycle after that.
REQ-024 Edge detection after a config write SHALL use the new src; the previous-src register SHALL be loaded with the new src value, so a write by itself SHALL NOT fire a spurious edge.
REQ-025 Each trig_in_led / trig_out_led SHALL have a hold counter. Any cycle with in_q / trig_out high SHALL reload it to LED_HOLD-1. The LED SHALL be high while the counter is nonzero or the source is high. The counter SHALL saturate at 0.
REQ-026 cfg_rd SHALL assert cfg_rd_valid for exactly 1 cycle, on the next cycle, with cfg_rdata. cfg_rdata SHALL be 0 when cfg_rd_valid is low.
REQ-027 Unmapped addresses SHALL read 0 and SHALL ignore writes.
REQ-028 Config reads SHALL return the written value with bits [15:10] read as 0.
REQ-029 A read and a write to the same address in the same cycle SHALL return the pre-write value.
REQ-030 cfg_rd and cfg_wr SHALL be accepted every cycle; there SHALL be no back-pressure.

Reset
REQ-031 On rst, all registers SHALL be set to: sel=8'hFF (disabled), invert=0, oneshot=0, width=0.
REQ-032 On rst, all counters, in_q and the previous-src registers SHALL be set to 0.
REQ-033 On the cycle after rst, trig_out, trig_in_led, trig_out_led, cfg_rdata and cfg_rd_valid SHALL all be 0.
REQ-034 A rst asserted mid-pulse or mid-read SHALL abort the operation: no cfg_rd_valid and no trig_out after reset.

Configuration
REQ-035 Macro TRIG_MATRIX_STATS_EN, when defined, SHALL add one 32-bit rising-edge counter per input on in_q, readable at address 0x80+i for i<NUM_IN.
REQ-036 Each edge counter SHALL saturate at 32'hFFFFFFFF.
REQ-037 A write of any data to address 0x80+i SHALL clear counter i. An edge in the same cycle as the clear SHALL leave the counter at 1.
REQ-038 Edge counters SHALL be set to 0 by rst.
REQ-039 Without TRIG_MATRIX_STATS_EN, no edge counters SHALL be instantiated; 0x80+ SHALL read 0 and writes there SHALL be ignored.

Verification
REQ-040 Scenario, level routing: write out3 = sel 5, invert 0; drive trig_in[5] high at cycle T -> trig_out[3] high at T+2; other outputs stay 0.
REQ-041 Scenario, invert and disable: write out0 = sel 2, invert 1 -> trig_out[0]=1 while in[2]=0. Then write sel=8'hFF -> trig_out[0]=0, with invert still set.
REQ-042 Scenario, oneshot: write out1 = sel 0, oneshot, width 4; pulse in[0] for 1 cycle at T, and again at T+2 -> trig_out[1] high exactly T+2..T+5; the second edge is ignored.
REQ-043 Scenario, reset and read: assert rst mid-oneshot -> trig_out=0 next cycle. Then read addr 1 -> cfg_rd_valid high for 1 cycle with 32'h000000FF.
REQ-044 Scenario, LED hold: with LED_HOLD=8, a 1-cycle pulse on in[7] -> trig_in_led[7] high for exactly 8 cycles after in_q.
REQ-045 Scenario, stats (TRIG_MATRIX_STATS_EN only): 3 edges on in[4], then read 0x84 -> 3. Write 0x84 and read again -> 0. Without the macro, reading 0x84 -> 0.
